bit_serial_dot_pe: RTL
======================

Name: bit_serial_dot_pe

Overview:
- Bit-serial dot-product processing element that consumes the 1-bit-per-lane activation vector produced by the upstream shift register file, MSB first.
- Multiplies each lane's bit by a parallel weight and accumulates the result with shift-and-add over DATA_WIDTH cycles.
- Drives the upstream file's shift (read) enable itself.
- Returns one signed dot-product result through a valid/ready handshake to the output/requant stage.

Parameters:
- DATA_WIDTH, 8, activation bit-width; equals the number of bit-serial cycles per operation.
- W_WIDTH, 8, signed weight width.
- VEC_LENGTH, 16, number of lanes; must be ≥2.
- ACC_WIDTH, W_WIDTH+DATA_WIDTH+$clog2(VEC_LENGTH), signed accumulator/result width (20 at defaults).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; asserted in the same cycle upstream writes (w_en) the shift file.
- w_in  input  [W_WIDTH-1:0] x VEC_LENGTH  signed weights; sampled only on an accepted start.
- act_bit  input  1 x VEC_LENGTH  current activation bit per lane (upstream d_out).
- shift_en  output  1  drives the upstream file's r_en.
- busy  output  1  high in every state except IDLE.
- res_data  output  [ACC_WIDTH-1:0]  signed dot-product result.
- res_valid  output  1  result available.
- res_ready  input  1  downstream accepts result.

Behaviour:
- Reset (synchronous, active-high, clock clk): state=IDLE, acc=0, bit_cnt=0, weight regs=0. Outputs: res_data=0, res_valid=0, shift_en=0, busy=0.
- Reset mid-operation (any state): abandons the operation, takes effect at the next edge, and applies all reset values; no partial result is emitted.
- States: IDLE, ACC, DONE.
- IDLE:
  - start=1 → latch w_in into weight regs, acc=0, bit_cnt=0, go to ACC.
  - start is accepted only in IDLE; in ACC/DONE it is ignored.
- ACC (exactly DATA_WIDTH cycles):
  - Every cycle: shift_en=1 and psum = Σ_j (act_bit[j] ? w_reg[j] : 0), sign-extended to ACC_WIDTH.
  - bit_cnt==0: acc <= psum (negated under SIGNED_ACT_EN).
  - Otherwise: acc <= (acc<<1) + psum.
  - bit_cnt increments each cycle; at bit_cnt==DATA_WIDTH-1 go to DONE.
  - The shift on the last ACC cycle is harmless; upstream reloads on the next w_en.
- DONE:
  - res_valid=1, res_data=acc, shift_en=0.
  - Both are held stable until res_valid&res_ready, then go to IDLE; res_valid falls in the IDLE cycle.
  - A start in the handshake cycle is ignored.
- Latency: start accepted at cycle T → ACC at T+1..T+DATA_WIDTH → res_valid first high at T+DATA_WIDTH+1.
- Throughput: one result per DATA_WIDTH+2 cycles with res_ready held high.
- Arithmetic:
  - All signed two's complement; no saturation.
  - ACC_WIDTH is sized so no overflow is possible for any input.
  - psum width is W_WIDTH+$clog2(VEC_LENGTH)+1 before extension.
- shift_en is a registered-state decode (state==ACC), glitch-free, with no combinational path from inputs.

Optional Feature:
- Macro: SIGNED_ACT_EN.
- Defined:
  - Activations are two's complement.
  - The MSB bit-plane (bit_cnt==0) contributes −psum, i.e. acc <= −psum, then shift-add as normal.
- Undefined:
  - Activations are unsigned; acc <= psum at bit_cnt==0.
  - ACC_WIDTH is unchanged in both builds.

Decomposition:
- Package bitsim_pe_pkg holds:
  - the state enum pe_state_e {IDLE, ACC, DONE};
  - a function acc_width(DATA_WIDTH, W_WIDTH, VEC_LENGTH).
- Sub-module masked_adder_tree:
  - purely combinational AND-mask plus balanced adder tree producing psum;
  - parameterised by W_WIDTH and VEC_LENGTH;
  - reused by other BitSim PEs.

Test Plan:
- Weights all 1, activations all 8'h01 (bit streams 0…01), res_ready=1 → shift_en high 8 cycles, res_valid at T+9, res_data=16.
- w_j=j (0..15), activations all 8'hFF → unsigned build res_data=30600; SIGNED_ACT_EN build res_data=−120.
- Weights all −128, activations all 8'h7F → res_data=−260096 (20'h C0800) in both builds.
- Backpressure: res_ready=0 for 5 cycles after res_valid, start pulsed during the hold:
  - result held stable and busy=1;
  - start ignored, no shift_en;
  - completes on res_ready=1, next cycle IDLE.
- Reset asserted at ACC bit_cnt==4 → next cycle state IDLE, res_valid=0, res_data=0, shift_en=0, busy=0; a fresh start then yields the correct result.
- Back-to-back: start reasserted the cycle after the handshake (IDLE) → second result is correct and independent of the first; acc is not carried over.

Source files
------------

// File: rtl/bitsim_pe_pkg.sv
// Shared types and sizing helpers for the BitSim bit-serial processing elements.
package bitsim_pe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } pe_state_e;

  // Signed accumulator width that cannot overflow for any weight/activation mix.
  function automatic int acc_width(input int data_width, input int w_width, input int vec_length);
    return w_width + data_width + $clog2(vec_length);
  endfunction

endpackage

// File: rtl/masked_adder_tree.sv
// Combinational AND-mask plus balanced adder tree: psum = sum of weights whose mask bit is set.
module masked_adder_tree #(
  parameter int W_WIDTH    = 8,
  parameter int VEC_LENGTH = 16
) (
  input  logic [VEC_LENGTH*W_WIDTH-1:0]           w_in,
  input  logic [VEC_LENGTH-1:0]                   mask,
  output logic signed [W_WIDTH+$clog2(VEC_LENGTH):0] psum
);

  localparam int PW = W_WIDTH + $clog2(VEC_LENGTH) + 1;
  localparam int N2 = 1 << $clog2(VEC_LENGTH);

  logic signed [PW-1:0] node [N2];

  // Leaves padded to a power of two; each level sums node[i] with node[i+span] in place.
  always_comb begin
    for (int i = 0; i < N2; i++) node[i] = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      if (mask[j]) begin
        node[j] = {{(PW-W_WIDTH){w_in[j*W_WIDTH+W_WIDTH-1]}}, w_in[j*W_WIDTH +: W_WIDTH]};
      end
    end
    for (int span = 1; span < N2; span = span * 2) begin
      for (int i = 0; i < N2; i = i + 2 * span) begin
        node[i] = node[i] + node[i+span];
      end
    end
    psum = node[0];
  end

endmodule

// File: rtl/bit_serial_dot_pe.sv
// Bit-serial dot-product PE: MSB-first activation planes, shift-and-add over DATA_WIDTH cycles.
// Define SIGNED_ACT_EN to treat activations as two's complement (MSB plane weighted negative).
module bit_serial_dot_pe
  import bitsim_pe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int W_WIDTH    = 8,
  parameter int VEC_LENGTH = 16,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, W_WIDTH, VEC_LENGTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [VEC_LENGTH*W_WIDTH-1:0] w_in,
  input  logic [VEC_LENGTH-1:0]         act_bit,
  output logic                          shift_en,
  output logic                          busy,
  output logic [ACC_WIDTH-1:0]          res_data,
  output logic                          res_valid,
  input  logic                          res_ready
);

  // state | meaning
  // IDLE  | waiting for start; weights latched on accept
  // ACC   | one activation bit-plane per cycle, shift_en high
  // DONE  | result presented, held until res_ready

  localparam int PW = W_WIDTH + $clog2(VEC_LENGTH) + 1;
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  pe_state_e state, state_nxt;
  logic [CW-1:0]                  bit_cnt;
  logic [VEC_LENGTH*W_WIDTH-1:0]  w_reg;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0]    psum_ext;
  logic signed [ACC_WIDTH-1:0]    acc_first;
  logic signed [PW-1:0]           psum;
  logic                           last_bit;

  masked_adder_tree #(
    .W_WIDTH   (W_WIDTH),
    .VEC_LENGTH(VEC_LENGTH)
  ) u_tree (
    .w_in(w_reg),
    .mask(act_bit),
    .psum(psum)
  );

  assign psum_ext = ACC_WIDTH'(psum);
  assign last_bit = (bit_cnt == CW'(DATA_WIDTH - 1));

`ifdef SIGNED_ACT_EN
  assign acc_first = -psum_ext;
`else
  assign acc_first = psum_ext;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    busy      = 1'b1;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ACC;
      end
      ACC: begin
        shift_en = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign res_data = res_valid ? acc : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      bit_cnt <= '0;
      w_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            w_reg   <= w_in;
            acc     <= '0;
            bit_cnt <= '0;
          end
        end
        ACC: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == '0) acc <= acc_first;
          else               acc <= (acc <<< 1) + psum_ext;
        end
        default: ;
      endcase
    end
  end

endmodule
